axi4lite_slave_regfile: RTL and testbench

- Parametrised AXI4-Lite slave register file.
- Next generation of the current 2-bit-address, 8-bit-data AXI4-Lite top: configurable data width, register count and read-only mask.
- Adds independent AW/W channel acceptance, byte write strobes, error responses and back-pressure on B/R.
- Sits behind an AXI4-Lite master; exposes every register as a flat output bus and pulses a write strobe per register.

---
 rtl/axi4lite_slave_regfile.sv | 174 +++++++++++++++++
 tb/tb_axi4lite_slave_regfile.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4lite_slave_regfile.sv
// Parametrised AXI4-Lite slave register file with byte strobes, RO registers,
// decode/slave error responses and one-deep AW/W holding registers.
module axi4lite_slave_regfile #(
  parameter int unsigned            ADDR_WIDTH = 4,
  parameter int unsigned            DATA_WIDTH = 32,
  parameter int unsigned            NUM_REGS   = 4,
  parameter logic [NUM_REGS-1:0]    RO_MASK    = '0,
  parameter logic [DATA_WIDTH-1:0]  RESET_VAL  = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ADDR_WIDTH-1:0]          awaddr,
  input  logic                           awvalid,
  output logic                           awready,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [DATA_WIDTH/8-1:0]        wstrb,
  input  logic                           wvalid,
  output logic                           wready,
  output logic [1:0]                     bresp,
  output logic                           bvalid,
  input  logic                           bready,
  input  logic [ADDR_WIDTH-1:0]          araddr,
  input  logic                           arvalid,
  output logic                           arready,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic [1:0]                     rresp,
  output logic                           rvalid,
  input  logic                           rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] ro_in,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned LSB    = $clog2(STRB_W);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] r_regs;

  logic                    r_aw_held;
  logic [ADDR_WIDTH-1:0]   r_awaddr;
  logic                    r_w_held;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [STRB_W-1:0]       r_wstrb;

  logic                    r_bvalid;
  logic [1:0]              r_bresp;
  logic                    r_rvalid;
  logic [1:0]              r_rresp;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic [NUM_REGS-1:0]     r_wr_pulse;

  logic [31:0]             w_aw_idx;
  logic [31:0]             w_ar_idx;
  logic [NUM_REGS-1:0]     w_wr_sel;
  logic                    w_wr_hit;
  logic                    w_wr_ro;
  logic [1:0]              w_wr_resp;
  logic                    w_commit;
  logic                    w_rd_hit;
  logic [DATA_WIDTH-1:0]   w_rd_data;

  // Shifting the whole address keeps the ignored low byte-lane bits syntactically used.
  assign w_aw_idx = 32'(r_awaddr) >> LSB;
  assign w_ar_idx = 32'(araddr) >> LSB;

  always_comb begin
    w_wr_sel = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (w_aw_idx == i) w_wr_sel[i] = 1'b1;
    end
  end

  assign w_wr_hit  = |w_wr_sel;
  assign w_wr_ro   = |(w_wr_sel & RO_MASK);
  assign w_wr_resp = !w_wr_hit ? RESP_DECERR : (w_wr_ro ? RESP_SLVERR : RESP_OKAY);
  assign w_commit  = r_aw_held && r_w_held && !r_bvalid;

  always_comb begin
    w_rd_hit  = 1'b0;
    w_rd_data = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (w_ar_idx == i) begin
        w_rd_hit  = 1'b1;
        w_rd_data = RO_MASK[i] ? ro_in[i*DATA_WIDTH +: DATA_WIDTH] : r_regs[i];
      end
    end
  end

  // Write address / data holding and B channel
  always_ff @(posedge clk) begin
    if (rst) begin
      r_aw_held  <= 1'b0;
      r_awaddr   <= '0;
      r_w_held   <= 1'b0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_bvalid   <= 1'b0;
      r_bresp    <= RESP_OKAY;
      r_wr_pulse <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= RESET_VAL;
      end
    end else begin
      r_wr_pulse <= '0;
      if (awvalid && !r_aw_held) begin
        r_aw_held <= 1'b1;
        r_awaddr  <= awaddr;
      end
      if (wvalid && !r_w_held) begin
        r_w_held <= 1'b1;
        r_wdata  <= wdata;
        r_wstrb  <= wstrb;
      end
      if (r_bvalid && bready) begin
        r_bvalid <= 1'b0;
      end
      if (w_commit) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
        r_bvalid  <= 1'b1;
        r_bresp   <= w_wr_resp;
        if (w_wr_hit && !w_wr_ro) begin
          r_wr_pulse <= w_wr_sel;
        end
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
          for (int unsigned k = 0; k < STRB_W; k++) begin
            if (w_wr_sel[i] && !RO_MASK[i] && r_wstrb[k]) begin
              r_regs[i][k*8 +: 8] <= r_wdata[k*8 +: 8];
            end
          end
        end
      end
    end
  end

  // Read channel: the mux samples r_regs before any same-edge commit lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rvalid <= 1'b0;
      r_rresp  <= RESP_OKAY;
      r_rdata  <= '0;
    end else if (!r_rvalid) begin
      if (arvalid) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rd_data;
        r_rresp  <= w_rd_hit ? RESP_OKAY : RESP_DECERR;
      end
    end else if (rready) begin
      r_rvalid <= 1'b0;
    end
  end

  always_comb begin
    reg_out = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (!RO_MASK[i]) reg_out[i*DATA_WIDTH +: DATA_WIDTH] = r_regs[i];
    end
  end

  assign awready  = !r_aw_held;
  assign wready   = !r_w_held;
  assign bvalid   = r_bvalid;
  assign bresp    = r_bresp;
  assign arready  = !r_rvalid;
  assign rvalid   = r_rvalid;
  assign rresp    = r_rresp;
  assign rdata    = r_rdata;
  assign wr_pulse = r_wr_pulse;

endmodule

// File: tb/tb_axi4lite_slave_regfile.sv
// Directed bench for axi4lite_slave_regfile with a response scoreboard and
// a small register model built from the stimulus.
module tb_axi4lite_slave_regfile;

  localparam int unsigned        AW  = 5;
  localparam int unsigned        DW  = 32;
  localparam int unsigned        NR  = 4;
  localparam logic [NR-1:0]      ROM = 4'b1000;
  localparam logic [DW-1:0]      RV  = 32'h5EED_0001;

  logic              clk = 1'b0;
  logic              rst;
  logic [AW-1:0]     awaddr;
  logic              awvalid;
  logic              awready;
  logic [DW-1:0]     wdata;
  logic [DW/8-1:0]   wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [AW-1:0]     araddr;
  logic              arvalid;
  logic              arready;
  logic [DW-1:0]     rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;
  logic [NR*DW-1:0]  reg_out;
  logic [NR*DW-1:0]  ro_in;
  logic [NR-1:0]     wr_pulse;

  axi4lite_slave_regfile #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NUM_REGS   (NR),
    .RO_MASK    (ROM),
    .RESET_VAL  (RV)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .awaddr   (awaddr),
    .awvalid  (awvalid),
    .awready  (awready),
    .wdata    (wdata),
    .wstrb    (wstrb),
    .wvalid   (wvalid),
    .wready   (wready),
    .bresp    (bresp),
    .bvalid   (bvalid),
    .bready   (bready),
    .araddr   (araddr),
    .arvalid  (arvalid),
    .arready  (arready),
    .rdata    (rdata),
    .rresp    (rresp),
    .rvalid   (rvalid),
    .rready   (rready),
    .reg_out  (reg_out),
    .ro_in    (ro_in),
    .wr_pulse (wr_pulse)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [1:0]    r;
  } rexp_t;

  int unsigned   n_pass  = 0;
  int unsigned   n_total = 0;
  logic [1:0]    exp_b_q[$];
  rexp_t         exp_r_q[$];
  logic [DW-1:0] m_regs [NR];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NR*DW-1:0] exp_out();
    logic [NR*DW-1:0] v;
    v = '0;
    for (int i = 0; i < NR; i++) begin
      if (!ROM[i]) v[i*DW +: DW] = m_regs[i];
    end
    return v;
  endfunction

  // Model the effect of a write; returns expected bresp and wr_pulse.
  task automatic model_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s,
                          output logic [1:0] resp, output logic [NR-1:0] pulse);
    int idx;
    idx   = int'(a >> 2);
    pulse = '0;
    if (idx >= NR) begin
      resp = 2'b11;
    end else if (ROM[idx]) begin
      resp = 2'b10;
    end else begin
      resp = 2'b00;
      pulse[idx] = 1'b1;
      for (int k = 0; k < 4; k++) begin
        if (s[k]) m_regs[idx][k*8 +: 8] = d[k*8 +: 8];
      end
    end
  endtask

  function automatic rexp_t model_rd(input logic [AW-1:0] a);
    rexp_t e;
    int idx;
    idx = int'(a >> 2);
    if (idx >= NR)   e = '{d: '0, r: 2'b11};
    else if (ROM[idx]) e = '{d: ro_in[idx*DW +: DW], r: 2'b00};
    else             e = '{d: m_regs[idx], r: 2'b00};
    return e;
  endfunction

  task automatic wait_b(input string tag, input logic [NR-1:0] exp_pulse);
    int c;
    logic [1:0] e;
    c = 0;
    while (!bvalid && c < 50) begin
      tick();
      c++;
    end
    if (!bvalid) begin
      chk({tag, "_b_timeout"}, 128'(bvalid), 128'(1'b1));
    end else if (exp_b_q.size() == 0) begin
      chk({tag, "_b_sb_empty"}, 128'(0), 128'(1));
    end else begin
      e = exp_b_q.pop_front();
      chk({tag, "_bresp"}, 128'(bresp), 128'(e));
      chk({tag, "_wr_pulse"}, 128'(wr_pulse), 128'(exp_pulse));
    end
  endtask

  task automatic pop_r(input string tag);
    int c;
    rexp_t e;
    c = 0;
    while (!rvalid && c < 50) begin
      tick();
      c++;
    end
    if (!rvalid) begin
      chk({tag, "_r_timeout"}, 128'(rvalid), 128'(1'b1));
    end else if (exp_r_q.size() == 0) begin
      chk({tag, "_r_sb_empty"}, 128'(0), 128'(1));
    end else begin
      e = exp_r_q.pop_front();
      chk({tag, "_rdata"}, 128'(rdata), 128'(e.d));
      chk({tag, "_rresp"}, 128'(rresp), 128'(e.r));
    end
  endtask

  task automatic wr(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d,
                    input logic [3:0] s);
    logic [1:0] resp;
    logic [NR-1:0] pulse;
    int c;
    model_wr(a, d, s, resp, pulse);
    exp_b_q.push_back(resp);
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1;
    c = 0;
    while (!(awready && wready) && c < 50) begin
      tick();
      c++;
    end
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    wait_b(tag, pulse);
    tick();
  endtask

  task automatic rd(input string tag, input logic [AW-1:0] a);
    int c;
    exp_r_q.push_back(model_rd(a));
    araddr = a;
    arvalid = 1'b1;
    c = 0;
    while (!arready && c < 50) begin
      tick();
      c++;
    end
    tick();
    arvalid = 1'b0;
    pop_r(tag);
    tick();
  endtask

  initial begin
    logic [1:0] resp;
    logic [NR-1:0] pulse;

    rst = 1'b1;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
    bready = 1'b1; araddr = '0; arvalid = 1'b0; rready = 1'b1;
    ro_in = '1;
    ro_in[3*DW +: DW] = 32'hCAFE_F00D;
    for (int i = 0; i < NR; i++) m_regs[i] = RV;
    tick(); tick(); tick();
    rst = 1'b0;
    tick();

    // Reset state
    chk("rst_awready", 128'(awready), 128'(1'b1));
    chk("rst_wready",  128'(wready),  128'(1'b1));
    chk("rst_arready", 128'(arready), 128'(1'b1));
    chk("rst_bvalid",  128'(bvalid),  128'(1'b0));
    chk("rst_rvalid",  128'(rvalid),  128'(1'b0));
    chk("rst_pulse",   128'(wr_pulse), 128'(0));
    chk("rst_reg_out", 128'(reg_out), 128'(exp_out()));

    // AW+W same cycle to 0x4: commit one edge after the handshake
    model_wr(5'h04, 32'hDEAD_BEEF, 4'hF, resp, pulse);
    exp_b_q.push_back(resp);
    awaddr = 5'h04; wdata = 32'hDEAD_BEEF; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    chk("t1_bvalid_early", 128'(bvalid), 128'(1'b0));
    chk("t1_awready_held", 128'(awready), 128'(1'b0));
    chk("t1_wready_held",  128'(wready), 128'(1'b0));
    tick();
    chk("t1_bvalid_n1", 128'(bvalid), 128'(1'b1));
    wait_b("t1", 4'b0010);
    tick();
    chk("t1_bvalid_clr", 128'(bvalid), 128'(1'b0));
    chk("t1_pulse_clr",  128'(wr_pulse), 128'(0));
    chk("t1_reg_out",    128'(reg_out), 128'(exp_out()));
    rd("t1_rd", 5'h04);

    // W alone, AW three cycles later, partial strobes
    wdata = 32'h1122_3344; wstrb = 4'h5; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    chk("t2_wready_held", 128'(wready), 128'(1'b0));
    tick();
    chk("t2_no_commit", 128'(bvalid), 128'(1'b0));
    tick();
    awaddr = 5'h04; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    chk("t2_bvalid_early", 128'(bvalid), 128'(1'b0));
    model_wr(5'h04, 32'h1122_3344, 4'h5, resp, pulse);
    exp_b_q.push_back(resp);
    tick();
    chk("t2_bvalid_n1", 128'(bvalid), 128'(1'b1));
    wait_b("t2", pulse);
    chk("t2_reg1", 128'(reg_out[DW +: DW]), 128'(32'hDE22_BE44));
    tick();
    rd("t2_rd", 5'h04);

    // Read-only register and out-of-range address
    wr("t3_ro", 5'h0C, 32'h1234_5678, 4'hF);
    chk("t3_reg_out", 128'(reg_out), 128'(exp_out()));
    rd("t3_rd", 5'h0C);
    wr("t4_dec", 5'h10, 32'h8765_4321, 4'hF);
    chk("t4_reg_out", 128'(reg_out), 128'(exp_out()));
    rd("t4_rd", 5'h10);
    wr("t4_nostrb", 5'h00, 32'hFFFF_FFFF, 4'h0);
    rd("t4_rd0", 5'h00);

    // Read and commit to the same register on the same edge
    exp_r_q.push_back(model_rd(5'h00));
    awaddr = 5'h00; wdata = 32'h0102_0304; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 5'h00; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    model_wr(5'h00, 32'h0102_0304, 4'hF, resp, pulse);
    exp_b_q.push_back(resp);
    pop_r("t5_rd_pre");
    wait_b("t5", pulse);
    tick();
    rd("t5_rd_post", 5'h00);

    // B back-pressure: second write waits until after the B handshake
    bready = 1'b0;
    model_wr(5'h08, 32'hA5A5_A5A5, 4'hF, resp, pulse);
    exp_b_q.push_back(resp);
    awaddr = 5'h08; wdata = 32'hA5A5_A5A5; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    tick();
    wait_b("t6a", 4'b0100);
    awaddr = 5'h08; wdata = 32'h5A5A_5A5A; awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    exp_b_q.push_back(2'b00);
    for (int i = 0; i < 5; i++) begin
      chk("t6_awready", 128'(awready), 128'(1'b0));
      chk("t6_wready",  128'(wready),  128'(1'b0));
      chk("t6_bvalid",  128'(bvalid),  128'(1'b1));
      chk("t6_bresp",   128'(bresp),   128'(2'b00));
      chk("t6_pulse",   128'(wr_pulse), 128'(0));
      chk("t6_reg2",    128'(reg_out[2*DW +: DW]), 128'(32'hA5A5_A5A5));
      tick();
    end
    bready = 1'b1;
    tick();
    chk("t6_b_hs", 128'(bvalid), 128'(1'b0));
    chk("t6_reg2_hs", 128'(reg_out[2*DW +: DW]), 128'(32'hA5A5_A5A5));
    m_regs[2] = 32'h5A5A_5A5A;
    tick();
    chk("t6_commit2", 128'(bvalid), 128'(1'b1));
    wait_b("t6b", 4'b0100);
    chk("t6_reg_out", 128'(reg_out), 128'(exp_out()));
    tick();

    // Reset with AW held and a read response pending
    awaddr = 5'h04; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    chk("t7_aw_held", 128'(awready), 128'(1'b0));
    rready = 1'b0;
    araddr = 5'h00; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    chk("t7_rvalid_pre", 128'(rvalid), 128'(1'b1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rready = 1'b1;
    for (int i = 0; i < NR; i++) m_regs[i] = RV;
    chk("t7_rvalid", 128'(rvalid), 128'(1'b0));
    chk("t7_bvalid", 128'(bvalid), 128'(1'b0));
    chk("t7_pulse",  128'(wr_pulse), 128'(0));
    chk("t7_rdata",  128'(rdata), 128'(0));
    chk("t7_awready", 128'(awready), 128'(1'b1));
    wdata = 32'h7777_7777; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("t7_no_commit", 128'(bvalid), 128'(1'b0));
    chk("t7_wready", 128'(wready), 128'(1'b0));
    chk("t7_reg_out", 128'(reg_out), 128'(exp_out()));
    rd("t7_rd", 5'h04);

    chk("sb_b_empty", 128'(exp_b_q.size()), 128'(0));
    chk("sb_r_empty", 128'(exp_r_q.size()), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
